// File: rtl/riscv_fetch_pkg.sv
// Shared types for the RISC-V instruction fetch stage: queue entry layout,
// fetch FSM states and instruction-size constants.
package riscv_fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  localparam int INSTR_BYTES = 4;

  // Force a byte address onto a 32-bit instruction boundary.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/riscv_fetch_queue.sv
// Synchronous FIFO of fetch_entry_t used both as the fetch queue and as the
// in-flight request PC tracker. Clear wins over push and pop. Storage is not
// reset; only pointers and the occupancy count are.
module riscv_fetch_queue
  import riscv_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic                   push_i,
  input  fetch_entry_t           data_i,
  input  logic                   pop_i,
  output logic [$clog2(DEPTH):0] count_o,
  output fetch_entry_t           head_o
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push;
  logic          do_pop;

  // Next pointers and count; a pop on an empty FIFO is ignored.
  always_comb begin
    do_push  = push_i && !clear_i;
    do_pop   = pop_i && !clear_i && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Control state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage write.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/riscv_fetch_stage.sv
// RISC-V IF stage: issues in-order word fetches, tags returned instructions
// with their PC in a fetch queue and presents the head to ID. A redirect
// flushes the queue and drops responses still in flight (DRAIN state).
// Optional macro RISCV_FETCH_PERF_EN adds stall/drop performance counters.
module riscv_fetch_stage
  import riscv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          FQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_if,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
`ifdef RISCV_FETCH_PERF_EN
  output logic [31:0] if_id_instr,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_drop_count
`else
  output logic [31:0] if_id_instr
`endif
);

  localparam int CW = $clog2(FQ_DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] q_count;
  logic [CW-1:0] pf_count;
  fetch_entry_t  q_head;
  fetch_entry_t  pf_head;
  fetch_entry_t  q_push_data;
  fetch_entry_t  pf_push_data;
  logic          credit_ok;
  logic          req_fire;
  logic          q_push;
  logic          q_pop;

  // Outstanding requests (pf_count) plus buffered entries may never exceed
  // the queue depth, so every response always has a free slot.
  assign credit_ok = ({1'b0, q_count} + {1'b0, pf_count}) < (CW+1)'(FQ_DEPTH);
  assign req_fire  = imem_req_valid && imem_req_ready;
  assign q_push    = imem_rsp_valid && !redirect_valid && (drop_q == '0);
  assign q_pop     = if_id_valid && !stall_if && !redirect_valid;

  // Build queue entries: response data tagged with its request PC.
  always_comb begin
    pf_push_data       = '0;
    pf_push_data.pc    = pc_q;
    q_push_data        = pf_head;
    q_push_data.instr  = imem_rsp_data;
  end

  riscv_fetch_queue #(.DEPTH(FQ_DEPTH)) u_fetch_q (
    .clk_i   (clk),
    .rst_i   (rst),
    .clear_i (redirect_valid),
    .push_i  (q_push),
    .data_i  (q_push_data),
    .pop_i   (q_pop),
    .count_o (q_count),
    .head_o  (q_head)
  );

  // In-flight PCs: one entry per accepted request, retired by every response
  // (kept or dropped), so its count is the outstanding-request count.
  riscv_fetch_queue #(.DEPTH(FQ_DEPTH)) u_pc_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .clear_i (1'b0),
    .push_i  (req_fire),
    .data_i  (pf_push_data),
    .pop_i   (imem_rsp_valid),
    .count_o (pf_count),
    .head_o  (pf_head)
  );

  // Fetch FSM next state, PC update, drop accounting and request valid.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    drop_d         = drop_q;
    imem_req_valid = 1'b0;
    case (state_q)
      FETCH:   imem_req_valid = !redirect_valid && credit_ok;
      DRAIN:   imem_req_valid = 1'b0;
      default: imem_req_valid = 1'b0;
    endcase
    if (rst) imem_req_valid = 1'b0;
    if (req_fire) pc_d = pc_q + 32'(INSTR_BYTES);
    if (imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - CW'(1);
    if (redirect_valid) begin
      pc_d   = align_pc(redirect_pc);
      drop_d = pf_count - CW'(imem_rsp_valid);
    end
    state_d = (drop_d != '0) ? DRAIN : FETCH;
  end

  // FSM, PC and drop counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
    end
  end

  assign imem_req_addr = pc_q;
  assign if_id_valid   = !rst && (q_count != '0);
  assign if_id_pc      = q_head.pc;
  assign if_id_instr   = q_head.instr;

`ifdef RISCV_FETCH_PERF_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_drop_q;

  // Free-running wrap-around event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_drop_q  <= '0;
    end else begin
      if (if_id_valid && stall_if) perf_stall_q <= perf_stall_q + 32'd1;
      if (imem_rsp_valid && (redirect_valid || (drop_q != '0)))
        perf_drop_q <= perf_drop_q + 32'd1;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_drop_count   = perf_drop_q;
`endif

`ifndef SYNTHESIS
  a_rsp_has_request: assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid |-> (pf_count != '0));
`endif

endmodule
